mc_bus_driver: RTL and testbench
================================

MC_BUS_DRIVER -- requirements
Module: mc_bus_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width for the ifmap and fltr channels; psum and result are 2*DATA_WIDTH.
REQ-002 SHALL have parameter NUM_COL, default 4, column count passed through for caster sizing (no logic dependency here).
REQ-003 SHALL have parameter TIMEOUT, default 256, the maximum number of WAIT cycles before abort.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ifmap_in_valid/ifmap_in_ready/ifmap_in_data  in/out/in  1/1/DATA_WIDTH: buffer-side ifmap stream.
REQ-006 SHALL have fltr_in_valid/fltr_in_ready/fltr_in_data  in/out/in  1/1/DATA_WIDTH: buffer-side filter stream.
REQ-007 SHALL have psum_in_valid/psum_in_ready/psum_in_data  in/out/in  1/1/2*DATA_WIDTH: buffer-side partial-sum stream.
REQ-008 SHALL have ifmap_data_M2B, fltr_data_M2B, psum_data_M2B  out  DATA_WIDTH/DATA_WIDTH/2*DATA_WIDTH: operands toward the multicaster.
REQ-009 SHALL have psum_data_B2M  in  2*DATA_WIDTH: result returned from the multicaster.
REQ-010 SHALL have CASTER_EN  out  3: per-caster enable, with bit0 for ifmap, bit1 for fltr and bit2 for psum.
REQ-011 SHALL have CASTER_READY  in  1 and CASTER_VALID  in  1: the multicaster's aggregated ready and result-valid signals.
REQ-012 SHALL have res_valid/res_ready/res_data  out/in/out  1/1/2*DATA_WIDTH: result stream back to the buffer.
REQ-013 SHALL have err_timeout  out  1 (sticky abort flag) and txn_cnt  out  16 (completed-transaction count).

Function
REQ-014 SHALL implement the FSM states FILL, ISSUE, WAIT and DRAIN.
REQ-015 In FILL, each channel SHALL keep a holding register and a full flag.
REQ-016 In FILL, x_in_ready SHALL equal ~full_x, and a handshake (valid&ready) SHALL capture the data and set full_x.
REQ-017 Channels SHALL fill independently, in any order, including all three in the same cycle.
REQ-018 In any state other than FILL, all x_in_ready SHALL be 0.
REQ-019 FILL SHALL go to ISSUE in the cycle after all three full flags are 1.
REQ-020 In ISSUE, *_M2B SHALL drive the holding registers continuously.
REQ-021 In ISSUE, if CASTER_READY=1, CASTER_EN SHALL be 3'b111 for exactly that cycle and the FSM SHALL go to WAIT; otherwise CASTER_EN SHALL stay 0 and the FSM SHALL stay in ISSUE.
REQ-022 The *_M2B outputs SHALL stay stable from entry to ISSUE until leaving WAIT.
REQ-023 In WAIT, a timeout counter SHALL increment each cycle.
REQ-024 In WAIT, CASTER_VALID=1 SHALL capture psum_data_B2M into the result register and go to DRAIN.
REQ-025 In WAIT, if the counter reaches TIMEOUT-1 without CASTER_VALID, the block SHALL set err_timeout, load the result register with 0 and go to DRAIN.
REQ-026 If CASTER_VALID and the timeout coincide, CASTER_VALID SHALL win: data captured, no error.
REQ-027 CASTER_VALID outside WAIT SHALL be ignored.
REQ-028 In DRAIN, res_valid SHALL be 1 and res_data SHALL hold the result register.
REQ-029 On res_ready=1 in DRAIN, the block SHALL clear all full flags, clear the timeout counter, increment txn_cnt (wrapping 0xFFFF->0x0000) and return to FILL.
REQ-030 res_valid SHALL never drop without a handshake.
REQ-031 err_timeout SHALL stay set until reset; it SHALL NOT block further transactions.
REQ-032 The minimum latency SHALL be: last operand handshake -> CASTER_EN pulse in 2 cycles (if CASTER_READY=1); CASTER_VALID -> res_valid in 1 cycle.
REQ-033 The block SHALL perform no arithmetic on data; widths SHALL pass through unchanged.

Reset
REQ-034 When rst=1 at a clk edge, the block SHALL enter state FILL, clear the full flags and all holding/result registers, and set outputs as follows: CASTER_EN=0, res_valid=0, res_data=0, *_M2B=0, err_timeout=0, txn_cnt=0, timeout counter=0, x_in_ready=1 in the first cycle after reset.
REQ-035 Reset asserted in any state, including mid-WAIT or mid-DRAIN, SHALL abandon the transaction with no result emitted.

Verification
REQ-036 Bench SHALL cover basic transaction: ifmap=0x0003, fltr=0x0004, psum=0x00000010 all valid same cycle, CASTER_READY=1, CASTER_VALID two cycles after the enable with B2M=0x0000001C -> one 3'b111 pulse, res_data=0x0000001C, txn_cnt=1.
REQ-037 Bench SHALL cover staggered fill: psum at cycle 0, fltr at cycle 3, ifmap at cycle 7 -> CASTER_EN pulse only after cycle 7, and each in_ready drops after its own capture.
REQ-038 Bench SHALL cover backpressure: CASTER_READY=0 for 5 cycles in ISSUE, then res_ready=0 for 4 cycles -> no enable until ready; res_valid and res_data held stable; no new capture.
REQ-039 Bench SHALL cover timeout: CASTER_VALID never asserted, TIMEOUT=8 -> res_valid with res_data=0 exactly 8 WAIT cycles after the enable, err_timeout=1, and the next transaction completes normally.
REQ-040 Bench SHALL cover mid-operation reset: rst pulsed during WAIT -> all outputs at reset values, and a subsequent CASTER_VALID produces no res_valid.
REQ-041 Bench SHALL cover counter wrap: txn_cnt preloaded by running 65536 transactions -> reads 0x0000.

Source files
------------

// File: rtl/mc_bus_driver.sv
// mc_bus_driver: buffer-side bus driver for the PE-array multicaster.
// Gathers ifmap/fltr/psum operands, fires the casters, returns the result.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifmap_in_*            ifmap operand stream (valid/ready/data, DATA_WIDTH)
//   fltr_in_*             filter operand stream (valid/ready/data, DATA_WIDTH)
//   psum_in_*             partial-sum stream (valid/ready/data, 2*DATA_WIDTH)
//   *_data_M2B            held operands toward the multicaster
//   psum_data_B2M         result coming back from the multicaster
//   CASTER_EN             enable pulse: bit0 ifmap, bit1 fltr, bit2 psum
//   CASTER_READY/VALID    multicaster aggregated ready / result valid
//   res_*                 result stream toward the buffer
//   err_timeout           sticky flag, set when a WAIT is abandoned
//   txn_cnt               completed-transaction counter (wraps)
module mc_bus_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      ifmap_in_valid,
  output logic                      ifmap_in_ready,
  input  logic [DATA_WIDTH-1:0]     ifmap_in_data,

  input  logic                      fltr_in_valid,
  output logic                      fltr_in_ready,
  input  logic [DATA_WIDTH-1:0]     fltr_in_data,

  input  logic                      psum_in_valid,
  output logic                      psum_in_ready,
  input  logic [2*DATA_WIDTH-1:0]   psum_in_data,

  output logic [DATA_WIDTH-1:0]     ifmap_data_M2B,
  output logic [DATA_WIDTH-1:0]     fltr_data_M2B,
  output logic [2*DATA_WIDTH-1:0]   psum_data_M2B,
  input  logic [2*DATA_WIDTH-1:0]   psum_data_B2M,

  output logic [2:0]                CASTER_EN,
  input  logic                      CASTER_READY,
  input  logic                      CASTER_VALID,

  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*DATA_WIDTH-1:0]   res_data,

  output logic                      err_timeout,
  output logic [15:0]               txn_cnt
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  // NUM_COL only sizes the casters downstream; reject nonsense early.
  if (NUM_COL < 1) begin : g_bad_cols
    $error("mc_bus_driver: NUM_COL must be >= 1");
  end

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  state_t st_q;
  state_t st_d;

  logic                  full_if;
  logic                  full_fl;
  logic                  full_ps;
  logic [DATA_WIDTH-1:0] if_q;
  logic [DATA_WIDTH-1:0] fl_q;
  logic [PW-1:0]         ps_q;
  logic [PW-1:0]         res_q;
  logic [CW-1:0]         to_q;
  logic                  err_q;
  logic [15:0]           txn_q;

  logic in_fill;
  logic in_wait;
  logic in_drain;
  logic all_full;
  logic hs_if;
  logic hs_fl;
  logic hs_ps;
  logic to_hit;
  logic res_hs;

  assign in_fill  = (st_q == FILL);
  assign in_wait  = (st_q == WAIT);
  assign in_drain = (st_q == DRAIN);

  assign ifmap_in_ready = in_fill & ~full_if;
  assign fltr_in_ready  = in_fill & ~full_fl;
  assign psum_in_ready  = in_fill & ~full_ps;

  assign hs_if = ifmap_in_valid & ifmap_in_ready;
  assign hs_fl = fltr_in_valid & fltr_in_ready;
  assign hs_ps = psum_in_valid & psum_in_ready;

  assign all_full = full_if & full_fl & full_ps;
  assign to_hit   = in_wait & (to_q == TO_LAST);
  assign res_hs   = in_drain & res_ready;

  // Holding registers only change in FILL, so the M2B
  // operands are stable across ISSUE and WAIT.
  assign ifmap_data_M2B = if_q;
  assign fltr_data_M2B  = fl_q;
  assign psum_data_M2B  = ps_q;

  assign res_data    = res_q;
  assign err_timeout = err_q;
  assign txn_cnt     = txn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= FILL;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    CASTER_EN = 3'b000;
    res_valid = 1'b0;
    unique case (st_q)
      FILL: begin
        if (all_full) begin
          st_d = ISSUE;
        end
      end
      ISSUE: begin
        if (CASTER_READY) begin
          CASTER_EN = 3'b111;
          st_d      = WAIT;
        end
      end
      WAIT: begin
        if (CASTER_VALID || to_hit) begin
          st_d = DRAIN;
        end
      end
      DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) begin
          st_d = FILL;
        end
      end
      default: begin
        st_d = FILL;
      end
    endcase
  end

  // Operand channels fill independently; flags clear on result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_if <= 1'b0;
      full_fl <= 1'b0;
      full_ps <= 1'b0;
      if_q    <= '0;
      fl_q    <= '0;
      ps_q    <= '0;
    end else if (res_hs) begin
      full_if <= 1'b0;
      full_fl <= 1'b0;
      full_ps <= 1'b0;
    end else begin
      if (hs_if) begin
        if_q    <= ifmap_in_data;
        full_if <= 1'b1;
      end
      if (hs_fl) begin
        fl_q    <= fltr_in_data;
        full_fl <= 1'b1;
      end
      if (hs_ps) begin
        ps_q    <= psum_in_data;
        full_ps <= 1'b1;
      end
    end
  end

  // Result capture. A valid landing on the last WAIT
  // cycle beats the timeout: data kept, no error.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
      to_q  <= '0;
    end else if (in_wait) begin
      to_q <= to_q + CW'(1);
      if (CASTER_VALID) begin
        res_q <= psum_data_B2M;
      end else if (to_hit) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
    end else if (res_hs) begin
      to_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q <= 16'h0000;
    end else if (res_hs) begin
      txn_q <= txn_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mc_bus_driver.sv
// tb_mc_bus_driver: scoreboard bench for mc_bus_driver.
// Expected results queued at stimulus time, popped on result handshake.
module tb_mc_bus_driver;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifmap_in_valid;
  logic          ifmap_in_ready;
  logic [DW-1:0] ifmap_in_data;
  logic          fltr_in_valid;
  logic          fltr_in_ready;
  logic [DW-1:0] fltr_in_data;
  logic          psum_in_valid;
  logic          psum_in_ready;
  logic [31:0]   psum_in_data;
  logic [DW-1:0] ifmap_data_M2B;
  logic [DW-1:0] fltr_data_M2B;
  logic [31:0]   psum_data_M2B;
  logic [31:0]   psum_data_B2M;
  logic [2:0]    CASTER_EN;
  logic          CASTER_READY;
  logic          CASTER_VALID;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          err_timeout;
  logic [15:0]   txn_cnt;

  int          n_run = 0;
  int          n_fail = 0;
  int          en_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mc_bus_driver #(
    .DATA_WIDTH(DW),
    .NUM_COL(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifmap_in_valid(ifmap_in_valid),
    .ifmap_in_ready(ifmap_in_ready),
    .ifmap_in_data(ifmap_in_data),
    .fltr_in_valid(fltr_in_valid),
    .fltr_in_ready(fltr_in_ready),
    .fltr_in_data(fltr_in_data),
    .psum_in_valid(psum_in_valid),
    .psum_in_ready(psum_in_ready),
    .psum_in_data(psum_in_data),
    .ifmap_data_M2B(ifmap_data_M2B),
    .fltr_data_M2B(fltr_data_M2B),
    .psum_data_M2B(psum_data_M2B),
    .psum_data_B2M(psum_data_B2M),
    .CASTER_EN(CASTER_EN),
    .CASTER_READY(CASTER_READY),
    .CASTER_VALID(CASTER_VALID),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .err_timeout(err_timeout),
    .txn_cnt(txn_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor sits on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && CASTER_EN != 3'b000) begin
      en_cnt++;
      chk("en_val", 32'(CASTER_EN), 32'h7);
    end
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("res_unexp", 32'(res_valid), 32'h0);
      else chk("res_data", res_data, exp_q.pop_front());
    end
  end

  task automatic drive_ops(input logic [15:0] a, input logic [15:0] f,
                           input logic [31:0] p, input logic [31:0] e);
    ifmap_in_data  = a;
    fltr_in_data   = f;
    psum_in_data   = p;
    ifmap_in_valid = 1'b1;
    fltr_in_valid  = 1'b1;
    psum_in_valid  = 1'b1;
    exp_q.push_back(e);
    tick();
    ifmap_in_valid = 1'b0;
    fltr_in_valid  = 1'b0;
    psum_in_valid  = 1'b0;
  endtask

  task automatic wait_en(input int budget);
    int c;
    c = 0;
    while (CASTER_EN != 3'b111 && c < budget) begin
      tick();
      c++;
    end
    chk("en_wait", 32'(CASTER_EN), 32'h7);
  endtask

  task automatic wait_res(input int budget);
    int c;
    c = 0;
    while (!res_valid && c < budget) begin
      tick();
      c++;
    end
    chk("res_wait", 32'(res_valid), 32'h1);
  endtask

  // Called in the enable cycle; CASTER_VALID comes cvd cycles later.
  task automatic finish_cv(input int cvd, input logic [31:0] b2m);
    repeat (cvd) tick();
    CASTER_VALID  = 1'b1;
    psum_data_B2M = b2m;
    tick();
    CASTER_VALID = 1'b0;
    wait_res(4);
    tick();
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] f,
                         input logic [31:0] p, input logic [31:0] b2m,
                         input int cvd);
    drive_ops(a, f, p, b2m);
    wait_en(8);
    finish_cv(cvd, b2m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst            = 1'b1;
    ifmap_in_valid = 1'b0;
    fltr_in_valid  = 1'b0;
    psum_in_valid  = 1'b0;
    ifmap_in_data  = '0;
    fltr_in_data   = '0;
    psum_in_data   = '0;
    psum_data_B2M  = '0;
    CASTER_READY   = 1'b1;
    CASTER_VALID   = 1'b0;
    res_ready      = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;

    chk("rst_en", 32'(CASTER_EN), 32'h0);
    chk("rst_rv", 32'(res_valid), 32'h0);
    chk("rst_rd", res_data, 32'h0);
    chk("rst_m2b", {16'(ifmap_data_M2B | fltr_data_M2B), psum_data_M2B[15:0]} | {16'h0, psum_data_M2B[31:16]}, 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);
    chk("rst_txn", 32'(txn_cnt), 32'h0);
    chk("rst_rdy", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h7);

    // Basic transaction, all operands in one cycle.
    e0 = en_cnt;
    ifmap_in_data  = 16'h0003;
    fltr_in_data   = 16'h0004;
    psum_in_data   = 32'h0000_0010;
    ifmap_in_valid = 1'b1;
    fltr_in_valid  = 1'b1;
    psum_in_valid  = 1'b1;
    exp_q.push_back(32'h0000_001C);
    tick();
    ifmap_in_valid = 1'b0;
    fltr_in_valid  = 1'b0;
    psum_in_valid  = 1'b0;
    chk("b_rdy_off", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h0);
    chk("b_en_fill", 32'(CASTER_EN), 32'h0);
    tick();
    chk("b_en_lat2", 32'(CASTER_EN), 32'h7);
    chk("b_m2b_if", 32'(ifmap_data_M2B), 32'h3);
    chk("b_m2b_fl", 32'(fltr_data_M2B), 32'h4);
    chk("b_m2b_ps", psum_data_M2B, 32'h10);
    tick();
    chk("b_en_once", 32'(CASTER_EN), 32'h0);
    tick();
    CASTER_VALID  = 1'b1;
    psum_data_B2M = 32'h0000_001C;
    tick();
    CASTER_VALID = 1'b0;
    chk("b_rv_lat1", 32'(res_valid), 32'h1);
    chk("b_rd", res_data, 32'h1C);
    tick();
    chk("b_rv_clr", 32'(res_valid), 32'h0);
    chk("b_txn1", 32'(txn_cnt), 32'h1);
    chk("b_pulses", 32'(en_cnt - e0), 32'h1);

    // Staggered fill: psum @0, fltr @3, ifmap @7.
    e0 = en_cnt;
    exp_q.push_back(32'h0000_00AA);
    psum_in_data  = 32'h0000_0020;
    psum_in_valid = 1'b1;
    tick();
    psum_in_valid = 1'b0;
    chk("s_ps_rdy", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h6);
    repeat (2) tick();
    fltr_in_data  = 16'h0002;
    fltr_in_valid = 1'b1;
    tick();
    fltr_in_valid = 1'b0;
    chk("s_fl_rdy", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h4);
    repeat (3) tick();
    ifmap_in_data  = 16'h0005;
    ifmap_in_valid = 1'b1;
    tick();
    ifmap_in_valid = 1'b0;
    chk("s_if_rdy", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h0);
    chk("s_no_early", 32'(en_cnt - e0), 32'h0);
    chk("s_en_0", 32'(CASTER_EN), 32'h0);
    tick();
    chk("s_en_lat2", 32'(CASTER_EN), 32'h7);
    finish_cv(2, 32'h0000_00AA);
    chk("s_txn2", 32'(txn_cnt), 32'h2);

    // Backpressure on both caster and result sides.
    e0 = en_cnt;
    CASTER_READY = 1'b0;
    drive_ops(16'h0011, 16'h0022, 32'h0000_0033, 32'h0000_0055);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_en_hold", 32'(CASTER_EN), 32'h0);
      chk("bp_m2b", {ifmap_data_M2B, fltr_data_M2B}, 32'h0011_0022);
      tick();
    end
    CASTER_READY = 1'b1;
    res_ready    = 1'b0;
    #1;
    chk("bp_en_go", 32'(CASTER_EN), 32'h7);
    tick();
    CASTER_VALID  = 1'b1;
    psum_data_B2M = 32'h0000_0055;
    tick();
    CASTER_VALID   = 1'b0;
    ifmap_in_data  = 16'hBEEF;
    ifmap_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rv_hold", 32'(res_valid), 32'h1);
      chk("bp_rd_hold", res_data, 32'h55);
      chk("bp_no_cap", 32'(ifmap_data_M2B), 32'h11);
      tick();
    end
    res_ready      = 1'b1;
    ifmap_in_valid = 1'b0;
    tick();
    chk("bp_rv_clr", 32'(res_valid), 32'h0);
    chk("bp_pulses", 32'(en_cnt - e0), 32'h1);
    chk("bp_txn3", 32'(txn_cnt), 32'h3);

    // Timeout: no CASTER_VALID, TIMEOUT=8.
    drive_ops(16'h0101, 16'h0202, 32'h0000_0303, 32'h0);
    wait_en(8);
    chk("to_err_pre", 32'(err_timeout), 32'h0);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("to_lat", 32'(n), 32'd9);
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_rd0", res_data, 32'h0);
    tick();
    run_txn(16'h0007, 16'h0008, 32'h0000_0009, 32'h0000_0077, 2);
    chk("to_sticky", 32'(err_timeout), 32'h1);
    chk("to_txn5", 32'(txn_cnt), 32'h5);

    // Reset pulsed while in WAIT.
    drive_ops(16'h00AB, 16'h00CD, 32'h0000_00EF, 32'h0000_0099);
    wait_en(8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mr_en", 32'(CASTER_EN), 32'h0);
    chk("mr_rv", 32'(res_valid), 32'h0);
    chk("mr_m2b", {ifmap_data_M2B, fltr_data_M2B}, 32'h0);
    chk("mr_m2b_ps", psum_data_M2B, 32'h0);
    chk("mr_err", 32'(err_timeout), 32'h0);
    chk("mr_txn", 32'(txn_cnt), 32'h0);
    chk("mr_rdy", 32'({ifmap_in_ready, fltr_in_ready, psum_in_ready}), 32'h7);
    CASTER_VALID  = 1'b1;
    psum_data_B2M = 32'h0000_1234;
    tick();
    CASTER_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mr_no_res", 32'(res_valid), 32'h0);
      tick();
    end
    chk("mr_rd", res_data, 32'h0);

    // CASTER_VALID on the last WAIT cycle beats the timeout.
    run_txn(16'h0F0F, 16'h0E0E, 32'h0000_0D0D, 32'h0000_C0C0, 8);
    chk("co_err", 32'(err_timeout), 32'h0);
    chk("co_txn1", 32'(txn_cnt), 32'h1);

    // Counter wrap, preloaded just short of the top.
    dut.txn_q = 16'hFFFE;
    run_txn(16'h0001, 16'h0002, 32'h0000_0003, 32'h0000_0004, 1);
    chk("w_ffff", 32'(txn_cnt), 32'hFFFF);
    run_txn(16'h0005, 16'h0006, 32'h0000_0007, 32'h0000_0008, 3);
    chk("w_wrap", 32'(txn_cnt), 32'h0);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
